// File: rtl/multicycle_ctrl_if.sv
// Bus bundle between the multicycle control FSM and the datapath.
//   Op, memReady     : instruction opcode and memory handshake (datapath -> ctrl)
//   PCWrite..PCSource: write enables and mux selects          (ctrl -> datapath)
//   illegalOp        : unsupported opcode seen in DECODE
//   stateOut         : current FSM state code (debug)
//   instrCount       : completed instruction fetches, CNT_WIDTH bits
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           Op;
  logic                 memReady;
  logic                 PCWrite;
  logic                 PCWriteCond;
  logic                 IorD;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 MemtoReg;
  logic                 RegDst;
  logic                 RegWrite;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ALUOp;
  logic [1:0]           PCSource;
  logic                 illegalOp;
  logic [3:0]           stateOut;
  logic [CNT_WIDTH-1:0] instrCount;

  modport master (
    input  Op, memReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegalOp, stateOut, instrCount
  );

  modport slave (
    output Op, memReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegalOp, stateOut, instrCount
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Sequences fetch / decode / execute / memory / writeback and drives the
// datapath write enables and mux selects through the bus interface.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : multicycle_ctrl_if.master (Op, memReady in; controls, debug out)
// memReady stretches FETCH, MEMRD and MEMWR; it is ignored elsewhere.
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ANDIEX  = 4'd10,
    IMMWB   = 4'd11,
    JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;

  // State register and retired-fetch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && bus.memReady)
        cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic. Codes 13-15 fall through to FETCH.
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:   state_nxt = bus.memReady ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_ANDI:      state_nxt = ANDIEX;
          OP_J:         state_nxt = JEX;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:  state_nxt = (bus.Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_nxt = bus.memReady ? MEMWB : MEMRD;
      MEMWB:   state_nxt = FETCH;
      MEMWR:   state_nxt = bus.memReady ? FETCH : MEMWR;
      RTYPEEX: state_nxt = RTYPEWB;
      RTYPEWB: state_nxt = FETCH;
      BEQEX:   state_nxt = FETCH;
      ADDIEX:  state_nxt = IMMWB;
      ANDIEX:  state_nxt = IMMWB;
      IMMWB:   state_nxt = FETCH;
      JEX:     state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Output decode. Reset overrides everything so an aborted instruction
  // cannot issue a write in the reset cycle.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegalOp   = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.memReady;
          bus.PCWrite = bus.memReady;
        end
        DECODE: begin
          bus.ALUSrcB = 2'b11;
          case (bus.Op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_J: bus.illegalOp = 1'b0;
            default:                bus.illegalOp = 1'b1;
          endcase
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEMWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        MEMWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        RTYPEEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        RTYPEWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        BEQEX: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = 2'b01;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
        end
        ADDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        ANDIEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          bus.ALUOp   = 2'b11;
        end
        IMMWB: begin
          bus.RegWrite = 1'b1;
        end
        JEX: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus.stateOut   = state;
  assign bus.instrCount = cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (CNT_WIDTH = 4).
// Each table row is one clock cycle: inputs applied, then the expected
// state code, control word and instruction count are compared before the edge.
module tb_multicycle_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_WIDTH(CW)) bus ();
  multicycle_ctrl #(.CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic          rst;
    logic [5:0]    op;
    logic          mr;
    logic [3:0]    st;
    logic [16:0]   ctl;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Control word order:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],illegalOp}
  function automatic logic [16:0] mk(logic pcw, logic pcwc, logic iord,
      logic mrd, logic mwr, logic irw, logic m2r, logic rd, logic rw,
      logic asa, logic [1:0] asb, logic [1:0] aop, logic [1:0] pcs, logic ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic [16:0] actual();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegalOp};
  endfunction

  logic [16:0] c_zero, c_fetch, c_fwait, c_dec, c_decill, c_memadr, c_memrd,
               c_memwb, c_memwr, c_rex, c_rwb, c_beq, c_addi, c_andi, c_immwb, c_j;

  task automatic check(string name, logic [3:0] est, logic [16:0] ectl, logic [CW-1:0] ecnt);
    n_cmp += 3;
    if (bus.stateOut !== est) begin
      n_bad++;
      $display("FAIL %s state: got %0d expected %0d", name, bus.stateOut, est);
    end
    if (actual() !== ectl) begin
      n_bad++;
      $display("FAIL %s ctl: got %b expected %b", name, actual(), ectl);
    end
    if (bus.instrCount !== ecnt) begin
      n_bad++;
      $display("FAIL %s count: got %0d expected %0d", name, bus.instrCount, ecnt);
    end
  endtask

  task automatic add(logic rst, logic [5:0] op, logic mr, logic [3:0] st,
                     logic [16:0] ctl, logic [CW-1:0] cnt);
    tbl.push_back('{rst, op, mr, st, ctl, cnt});
  endtask

  initial begin
    c_zero   = '0;
    c_fetch  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    c_fwait  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    c_dec    = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    c_decill = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    c_memadr = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    c_memrd  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_memwb  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    c_memwr  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_rex    = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    c_rwb    = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    c_beq    = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    c_addi   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    c_andi   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0);
    c_immwb  = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    c_j      = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);

    // R-type: 0,1,6,7
    add(0, 6'b000000, 1, 0,  c_fetch,  0);
    add(0, 6'b000000, 1, 1,  c_dec,    1);
    add(0, 6'b000000, 1, 6,  c_rex,    1);
    add(0, 6'b000000, 1, 7,  c_rwb,    1);
    // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4
    add(0, 6'b100011, 1, 0,  c_fetch,  1);
    add(0, 6'b100011, 1, 1,  c_dec,    2);
    add(0, 6'b100011, 1, 2,  c_memadr, 2);
    add(0, 6'b100011, 0, 3,  c_memrd,  2);
    add(0, 6'b100011, 0, 3,  c_memrd,  2);
    add(0, 6'b100011, 1, 3,  c_memrd,  2);
    add(0, 6'b100011, 1, 4,  c_memwb,  2);
    // beq, memReady low in BEQEX must be ignored
    add(0, 6'b000100, 1, 0,  c_fetch,  2);
    add(0, 6'b000100, 1, 1,  c_dec,    3);
    add(0, 6'b000100, 0, 8,  c_beq,    3);
    // j
    add(0, 6'b000010, 1, 0,  c_fetch,  3);
    add(0, 6'b000010, 1, 1,  c_dec,    4);
    add(0, 6'b000010, 1, 12, c_j,      4);
    // andi
    add(0, 6'b001100, 1, 0,  c_fetch,  4);
    add(0, 6'b001100, 1, 1,  c_dec,    5);
    add(0, 6'b001100, 1, 10, c_andi,   5);
    add(0, 6'b001100, 1, 11, c_immwb,  5);
    // illegal opcode: single DECODE cycle then FETCH
    add(0, 6'b111111, 1, 0,  c_fetch,  5);
    add(0, 6'b111111, 1, 1,  c_decill, 6);
    // fetch stretched by one wait cycle, then sw stalled and reset in MEMWR
    add(0, 6'b101011, 0, 0,  c_fwait,  6);
    add(0, 6'b101011, 1, 0,  c_fetch,  6);
    add(0, 6'b101011, 1, 1,  c_dec,    7);
    add(0, 6'b101011, 1, 2,  c_memadr, 7);
    add(0, 6'b101011, 0, 5,  c_memwr,  7);
    add(1, 6'b101011, 0, 5,  c_zero,   7);
    // sw after reset, no waits: 0,1,2,5
    add(0, 6'b101011, 1, 0,  c_fetch,  0);
    add(0, 6'b101011, 1, 1,  c_dec,    1);
    add(0, 6'b101011, 1, 2,  c_memadr, 1);
    add(0, 6'b101011, 1, 5,  c_memwr,  1);
    // addi
    add(0, 6'b001000, 1, 0,  c_fetch,  1);
    add(0, 6'b001000, 1, 1,  c_dec,    2);
    add(0, 6'b001000, 1, 9,  c_addi,   2);
    add(0, 6'b001000, 1, 11, c_immwb,  2);

    reset = 1'b1;
    bus.Op = 6'b000000;
    bus.memReady = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      reset        = tbl[i].rst;
      bus.Op       = tbl[i].op;
      bus.memReady = tbl[i].mr;
      #2;
      check($sformatf("row%0d", i), tbl[i].st, tbl[i].ctl, tbl[i].cnt);
      @(posedge clk); #1;
    end

    // Counter wrap: illegal-op instructions (2 cycles each) from count 2.
    reset = 1'b0;
    bus.Op = 6'b111111;
    bus.memReady = 1'b1;
    for (int k = 0; k < 15; k++) begin
      logic [CW-1:0] exp_cnt;
      exp_cnt = CW'(2 + k);
      #2;
      check($sformatf("wrapF%0d", k), 4'd0, c_fetch, exp_cnt);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1'b1;
      #2;
      check($sformatf("wrapD%0d", k), 4'd1, c_decill, exp_cnt);
      @(posedge clk); #1;
    end
    // 2 + 15 = 17 -> 1 after wrapping through 15 -> 0
    #2;
    check("wrap_end", 4'd0, c_fetch, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback for each instruction. Drives the mux selects, the write enables and the 2-bit ALUOp that the ALU control decoder turns into a 4-bit ALU operation. A memory ready handshake stretches the memory cycles.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter instrCount.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
Op  input  6  opcode, instruction bits [31:26] from the instruction register
memReady  input  1  memory has completed the current read or write this cycle
PCWrite  output  1  unconditional PC write enable
PCWriteCond  output  1  PC write enable when the ALU Zero flag is set (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load enable
MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination register select: 0 = rt, 1 = rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
ALUOp  output  2  00 = add, 01 = sub, 10 = use funct, 11 = and
PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
illegalOp  output  1  pulses while in DECODE with an unsupported opcode
stateOut  output  4  current state code, for debug
instrCount  output  CNT_WIDTH  count of completed instruction fetches

Behaviour:
- State register is 4 bits. Outputs are decoded from the state combinationally, plus memReady/Op where stated below.
- Any output not listed for a state is 0.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ANDIEX=10, IMMWB=11, JEX=12. Codes 13-15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- FETCH:
  - Outputs: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1, and instrCount increments on that edge.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target computed). Next state by Op:
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 (R-type) -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 001000 (addi) -> ADDIEX
  - 001100 (andi) -> ANDIEX
  - 000010 (j) -> JEX
  - any other Op -> FETCH, with illegalOp=1 for this one cycle; PC is already advanced and the instruction is skipped.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD if Op=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until memReady=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until memReady=1, then FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RTYPEWB.
- RTYPEWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state IMMWB.
- ANDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next state IMMWB. Zero-extension of the andi immediate is the extender's job, not this block's.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- JEX: PCWrite=1, PCSource=10. Next state FETCH.
- Latency: instruction cycles with memReady tied high:
  - R-type, addi, andi, sw: 4
  - beq, j: 3
  - lw: 5
  - Each wait cycle adds 1.
- Reset while reset=1:
  - PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite and RegWrite are forced to 0; illegalOp=0; all selects read 0.
  - State=FETCH and instrCount=0 on the next edge.
  - Reset mid-instruction, including during memory waits, aborts with no write issued in the reset cycle.
- memReady is ignored in states without a memory access.
- instrCount wraps modulo 2^CNT_WIDTH.

Test Plan:
- Reset asserted in MEMWR with memReady=0 -> MemWrite=0 in the reset cycle; stateOut=0 and instrCount=0 after the edge.
- R-type (Op=000000), memReady=1 -> stateOut 0,1,6,7,0; ALUOp=10 in state 6; RegWrite=1 and RegDst=1 in state 7; instrCount=1.
- lw (Op=100011), memReady low for 2 cycles in MEMRD -> stateOut 0,1,2,3,3,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4.
- beq then j -> BEQEX shows PCWriteCond=1, PCSource=01, ALUOp=01; JEX shows PCWrite=1, PCSource=10; each instruction takes 3 cycles.
- andi (Op=001100) -> ALUOp=11 in state 10; IMMWB shows RegDst=0 and RegWrite=1.
- Op=111111 -> illegalOp=1 for exactly the DECODE cycle, then FETCH; no RegWrite or MemWrite is asserted.
- 2^CNT_WIDTH fetches with CNT_WIDTH=4 -> instrCount wraps from 15 to 0.
